// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: default widths, the MEM/WB payload
// layout and the skid-buffer state encoding.
package mips_pkg;

    localparam int unsigned WORD_LEN        = 32;
    localparam int unsigned REG_32_ADDR_LEN = 5;

    // Field order matches the packed vector built by mem_wb_stage_reg (MSB first).
    typedef struct packed {
        logic                       wb_en;
        logic                       mem_rd_en;
        logic [REG_32_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]        alu_result;
        logic [WORD_LEN-1:0]        memread;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    // Packed payload width for a given data word and register address width.
    function automatic int unsigned payload_width(input int unsigned word_len,
                                                  input int unsigned addr_len);
        return 2 + addr_len + 2 * word_len;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-slot valid/ready register stage. MAIN drives the outputs; SKID
// catches the one payload accepted while downstream stalls, so upstream ready
// depends only on registered state.
module pipe_skid_buffer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    import mips_pkg::*;

    skid_state_t       state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    // Slot/state update; reset beats flush, flush beats every handshake and
    // leaves the slot contents untouched (outputs are qualified by out_valid).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_q  <= in_data;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        skid_q  <= in_data;
                        state_q <= SKID;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                SKID: begin
                    // in_ready is low here, so no new payload can arrive.
                    if (out_ready) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM-to-WB pipeline register: packs the memory-stage payload into a skid
// buffer, applies the x0 no-write rule, selects writeback data, drives the WB
// forwarding tap and counts back-pressure cycles.
module mem_wb_stage_reg #(
    parameter int unsigned WORD_LEN     = mips_pkg::WORD_LEN,
    parameter int unsigned REG_ADDR_LEN = mips_pkg::REG_32_ADDR_LEN,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_wb_en,
    input  logic                    i_mem_rd_en,
    input  logic [REG_ADDR_LEN-1:0] i_dest,
    input  logic [WORD_LEN-1:0]     i_alu_result,
    input  logic [WORD_LEN-1:0]     i_memread,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_wb_en,
    output logic [REG_ADDR_LEN-1:0] o_dest,
    output logic [WORD_LEN-1:0]     o_wb_data,
    output logic                    o_mem_rd_en,
    output logic                    o_fwd_valid,
    output logic [REG_ADDR_LEN-1:0] o_fwd_dest,
    output logic [WORD_LEN-1:0]     o_fwd_data,
    output logic [CNT_W-1:0]        o_stall_cnt
);
    import mips_pkg::*;

    localparam int unsigned DATA_W   = payload_width(WORD_LEN, REG_ADDR_LEN);
    // Bit positions inside the packed payload {wb_en, mem_rd_en, dest, alu, memread}.
    localparam int unsigned ALU_LSB  = WORD_LEN;
    localparam int unsigned DEST_LSB = 2 * WORD_LEN;
    localparam int unsigned RD_BIT   = DEST_LSB + REG_ADDR_LEN;
    localparam int unsigned WB_BIT   = RD_BIT + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                    cap_wb_en;
    logic [DATA_W-1:0]       in_payload;
    logic [DATA_W-1:0]       main_payload;
    logic                    main_wb_en;
    logic                    main_mem_rd_en;
    logic [REG_ADDR_LEN-1:0] main_dest;
    logic [WORD_LEN-1:0]     main_alu_result;
    logic [WORD_LEN-1:0]     main_memread;
    logic [WORD_LEN-1:0]     wb_data;
    logic [CNT_W-1:0]        stall_cnt_q;

    // x0 is hard-wired to zero, so a write to it is dropped at capture.
    assign cap_wb_en  = i_wb_en & (i_dest != '0);
    assign in_payload = {cap_wb_en, i_mem_rd_en, i_dest, i_alu_result, i_memread};

    pipe_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (i_sys_clk),
        .rst       (i_sys_rst),
        .flush     (i_flush),
        .in_valid  (i_valid),
        .in_ready  (o_ready),
        .in_data   (in_payload),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .out_data  (main_payload)
    );

    assign main_wb_en      = main_payload[WB_BIT];
    assign main_mem_rd_en  = main_payload[RD_BIT];
    assign main_dest       = main_payload[DEST_LSB +: REG_ADDR_LEN];
    assign main_alu_result = main_payload[ALU_LSB +: WORD_LEN];
    assign main_memread    = main_payload[0 +: WORD_LEN];

    // Writeback select: loads return memory data, everything else the ALU result.
    always_comb begin
        wb_data = main_alu_result;
        if (main_mem_rd_en) begin
            wb_data = main_memread;
        end
    end

    assign o_wb_en     = main_wb_en & o_valid;
    assign o_dest      = main_dest;
    assign o_wb_data   = wb_data;
    assign o_mem_rd_en = main_mem_rd_en;

    assign o_fwd_valid = o_valid & main_wb_en;
    assign o_fwd_dest  = main_dest;
    assign o_fwd_data  = wb_data;

    // Saturating back-pressure counter; only reset clears it, flush does not.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            stall_cnt_q <= '0;
        end else if (o_valid && !i_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Bench for mem_wb_stage_reg: a queue-based model of the stage (at most two
// held payloads, head drives the outputs) checked every cycle, plus directed
// sequences with literal expectations.
module tb_mem_wb_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, wb_en, mem_rd_en, flush, ready;
    logic [4:0]  dest;
    logic [31:0] alu, memr;

    logic        o_ready, o_valid, o_wb_en, o_mem_rd_en, o_fwd_valid;
    logic [4:0]  o_dest, o_fwd_dest;
    logic [31:0] o_wb_data, o_fwd_data;
    logic [15:0] o_stall_cnt;

    logic        c2_ready, c2_valid, c2_wb_en, c2_mem_rd_en, c2_fwd_valid;
    logic [4:0]  c2_dest, c2_fwd_dest;
    logic [31:0] c2_wb_data, c2_fwd_data;
    logic [1:0]  c2_stall_cnt;

    mem_wb_stage_reg #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_W(16)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_valid(valid), .o_ready(o_ready),
        .i_wb_en(wb_en), .i_mem_rd_en(mem_rd_en), .i_dest(dest), .i_alu_result(alu),
        .i_memread(memr), .i_flush(flush), .o_valid(o_valid), .i_ready(ready),
        .o_wb_en(o_wb_en), .o_dest(o_dest), .o_wb_data(o_wb_data),
        .o_mem_rd_en(o_mem_rd_en), .o_fwd_valid(o_fwd_valid), .o_fwd_dest(o_fwd_dest),
        .o_fwd_data(o_fwd_data), .o_stall_cnt(o_stall_cnt)
    );

    mem_wb_stage_reg #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_W(2)) dut_c2 (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_valid(valid), .o_ready(c2_ready),
        .i_wb_en(wb_en), .i_mem_rd_en(mem_rd_en), .i_dest(dest), .i_alu_result(alu),
        .i_memread(memr), .i_flush(flush), .o_valid(c2_valid), .i_ready(ready),
        .o_wb_en(c2_wb_en), .o_dest(c2_dest), .o_wb_data(c2_wb_data),
        .o_mem_rd_en(c2_mem_rd_en), .o_fwd_valid(c2_fwd_valid), .o_fwd_dest(c2_fwd_dest),
        .o_fwd_data(c2_fwd_data), .o_stall_cnt(c2_stall_cnt)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        wb_en;
        logic        rd;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } pl_t;

    pl_t q[$];
    int  m_cnt = 0;

    initial forever begin
        pl_t p;
        bit  v_now, r_now;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            v_now = (q.size() > 0);
            r_now = (q.size() < 2);
            if (v_now && !ready && m_cnt < 65535) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (v_now && ready) void'(q.pop_front());
                if (valid && r_now) begin
                    p.wb_en = wb_en && (dest != 5'd0);
                    p.rd    = mem_rd_en;
                    p.dest  = dest;
                    p.alu   = alu;
                    p.mem   = memr;
                    q.push_back(p);
                end
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    initial forever begin
        logic [31:0] exp_data;
        @(negedge clk);
        if (chk_en) begin
            check("o_valid", o_valid, q.size() > 0);
            check("o_ready", o_ready, q.size() < 2);
            check("o_stall_cnt", o_stall_cnt, m_cnt);
            check("c2_stall_cnt", c2_stall_cnt, (m_cnt > 3) ? 3 : m_cnt);
            if (q.size() > 0) begin
                exp_data = q[0].rd ? q[0].mem : q[0].alu;
                check("o_wb_en", o_wb_en, q[0].wb_en);
                check("o_fwd_valid", o_fwd_valid, q[0].wb_en);
                check("o_dest", o_dest, q[0].dest);
                check("o_fwd_dest", o_fwd_dest, q[0].dest);
                check("o_mem_rd_en", o_mem_rd_en, q[0].rd);
                check("o_wb_data", o_wb_data, exp_data);
                check("o_fwd_data", o_fwd_data, exp_data);
            end else begin
                check("o_wb_en_idle", o_wb_en, 1'b0);
                check("o_fwd_valid_idle", o_fwd_valid, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic v, input logic we, input logic rd, input logic [4:0] d,
                        input logic [31:0] a, input logic [31:0] m);
        valid     = v;
        wb_en     = we;
        mem_rd_en = rd;
        dest      = d;
        alu       = a;
        memr      = m;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cyc();
        cyc();
        chk_en = 1'b1;
        // Reset state
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_wb_en", o_wb_en, 1'b0);
        check("rst_dest", o_dest, 5'd0);
        check("rst_wb_data", o_wb_data, 32'd0);
        check("rst_mem_rd_en", o_mem_rd_en, 1'b0);
        check("rst_fwd_valid", o_fwd_valid, 1'b0);
        check("rst_cnt", o_stall_cnt, 16'd0);
        rst = 1'b0;

        // Back-to-back stream
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b1, 1'b0, 5'(k), 32'h10 + 32'(k - 1), 32'hFFFF_0000);
            cyc();
            check("stream_valid", o_valid, 1'b1);
            check("stream_dest", o_dest, 5'(k));
            check("stream_data", o_wb_data, 32'h10 + 32'(k - 1));
            check("stream_ready", o_ready, 1'b1);
        end
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cyc();
        check("stream_drained", o_valid, 1'b0);
        check("stream_cnt", o_stall_cnt, 16'd0);

        // Writeback mux
        send(1'b1, 1'b1, 1'b1, 5'd5, 32'h40, 32'hDEAD_BEEF);
        cyc();
        check("load_data", o_wb_data, 32'hDEAD_BEEF);
        check("load_fwd_data", o_fwd_data, 32'hDEAD_BEEF);
        send(1'b1, 1'b1, 1'b0, 5'd5, 32'h40, 32'hDEAD_BEEF);
        cyc();
        check("alu_data", o_wb_data, 32'h40);
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cyc();

        // Back-pressure into SKID, then drain
        ready = 1'b0;
        send(1'b1, 1'b1, 1'b0, 5'd6, 32'h60, 32'd0);
        cyc();
        send(1'b1, 1'b1, 1'b0, 5'd7, 32'h70, 32'd0);
        cyc();
        check("skid_ready", o_ready, 1'b0);
        check("skid_valid", o_valid, 1'b1);
        check("skid_head", o_dest, 5'd6);
        check("skid_cnt1", o_stall_cnt, 16'd1);
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cyc();
        check("skid_cnt2", o_stall_cnt, 16'd2);
        cyc();
        check("skid_cnt3", o_stall_cnt, 16'd3);
        ready = 1'b1;
        cyc();
        check("drain_dest", o_dest, 5'd7);
        check("drain_data", o_wb_data, 32'h70);
        check("drain_ready", o_ready, 1'b1);
        check("drain_cnt", o_stall_cnt, 16'd3);
        cyc();
        check("drain_empty", o_valid, 1'b0);

        // x0 rule
        send(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'd0);
        cyc();
        check("x0_valid", o_valid, 1'b1);
        check("x0_wb_en", o_wb_en, 1'b0);
        check("x0_fwd_valid", o_fwd_valid, 1'b0);
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cyc();

        // Flush in SKID with a new payload offered
        ready = 1'b0;
        send(1'b1, 1'b1, 1'b0, 5'd10, 32'hA0, 32'd0);
        cyc();
        send(1'b1, 1'b1, 1'b0, 5'd11, 32'hB0, 32'd0);
        cyc();
        check("pre_flush_ready", o_ready, 1'b0);
        flush = 1'b1;
        send(1'b1, 1'b1, 1'b0, 5'd12, 32'hCC, 32'd0);
        cyc();
        check("flush_valid", o_valid, 1'b0);
        check("flush_ready", o_ready, 1'b1);
        check("flush_keeps_cnt", o_stall_cnt, 16'd5);
        flush = 1'b0;
        ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("flush_no_ghost", o_valid, 1'b0);
        end

        // Saturation on the 2-bit counter, then reset mid-stall
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst2_cnt", c2_stall_cnt, 2'd0);
        ready = 1'b0;
        send(1'b1, 1'b1, 1'b0, 5'd13, 32'hD0, 32'd0);
        cyc();
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (5) cyc();
        check("sat_c2", c2_stall_cnt, 2'd3);
        check("sat_c16", o_stall_cnt, 16'd5);
        rst = 1'b1;
        cyc();
        check("rst_mid_valid", o_valid, 1'b0);
        check("rst_mid_c2", c2_stall_cnt, 2'd0);
        check("rst_mid_c16", o_stall_cnt, 16'd0);
        check("rst_mid_ready", o_ready, 1'b1);
        rst = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            send(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                 (($urandom % 6) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            rst   = ($urandom % 80) == 0;
            cyc();
        end
        rst = 1'b0; flush = 1'b0; ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_reg.md
# mem_wb_stage_reg

Parametrised MEM-to-WB pipeline stage with a valid/ready handshake, a two-entry skid buffer, synchronous flush and writeback-data selection. It sits between the data-memory stage and the register-file write port. It also drives a WB forwarding tap for the hazard unit and a saturating back-pressure counter. Payload widths are parameters, so the same block serves the 32-bit core and wider variants.

## Interface
- `WORD_LEN`, 32, data word width
- `REG_ADDR_LEN`, 5, register-file address width
- `CNT_W`, 16, stall-counter width
- `i_sys_clk` in 1, clock; all logic is on the rising edge
- `i_sys_rst` in 1, reset; synchronous, active-high
- `i_valid` in 1, upstream payload valid
- `o_ready` out 1, stage can accept a payload this cycle
- `i_wb_en` in 1, writeback enable
- `i_mem_rd_en` in 1, instruction is a load; selects memory data for writeback
- `i_dest` in REG_ADDR_LEN, destination register
- `i_alu_result` in WORD_LEN, ALU result
- `i_memread` in WORD_LEN, memory read data
- `i_flush` in 1, discard all held and incoming payloads
- `o_valid` out 1, downstream payload valid
- `i_ready` in 1, downstream accepts
- `o_wb_en` out 1, writeback enable, gated by o_valid
- `o_dest` out REG_ADDR_LEN, destination register
- `o_wb_data` out WORD_LEN, o_mem_rd_en ? memread : alu_result
- `o_mem_rd_en` out 1, registered load flag
- `o_fwd_valid` out 1, o_valid & o_wb_en
- `o_fwd_dest` out REG_ADDR_LEN, equal to o_dest
- `o_fwd_data` out WORD_LEN, equal to o_wb_data
- `o_stall_cnt` out CNT_W, count of back-pressure cycles

## Operation
- Payload: {wb_en, mem_rd_en, dest, alu_result, memread}, captured on a handshake (i_valid & o_ready).
- Capture rule: if i_dest == 0, wb_en is stored as 0, because x0 is never written.
- Two register slots: MAIN, which drives the outputs, and SKID. The state machine:
  - EMPTY:
    - i_valid → load MAIN, go to FULL.
  - FULL:
    - i_valid & i_ready → reload MAIN, stay in FULL.
    - i_valid & !i_ready → load SKID, go to SKID.
    - !i_valid & i_ready → go to EMPTY.
    - Otherwise hold.
  - SKID:
    - o_ready = 0.
    - i_ready → MAIN ← SKID, go to FULL. The upstream cannot present new data in this state.
- o_ready = (state != SKID). o_valid = (state != EMPTY).
- Flush:
  - i_flush = 1 → next state is EMPTY.
  - Any payload handshaken in the same cycle is dropped.
  - Payload registers hold their values; the outputs are masked by o_valid.
  - Flush has priority over every other transition.
- Stall counter:
  - Increments on each cycle with o_valid & !i_ready.
  - Saturates at all-ones.
  - Cleared only by reset.
  - Flush does not clear it.
- o_wb_en = MAIN.wb_en & o_valid.

## Timing
- Latency: 1 cycle from handshake to o_valid when the stage is EMPTY or draining.
- o_ready is driven from state only; there is no combinational path from i_ready to o_ready.
- Output data is a combinational mux of MAIN only.
- Reset (takes effect at the next edge):
  - State is EMPTY, all payload registers are 0, o_stall_cnt = 0.
  - Outputs then read: o_valid = 0, o_ready = 1, o_wb_en = 0, o_dest = 0, o_wb_data = 0, o_mem_rd_en = 0, o_fwd_valid = 0.
- Reset asserted mid-operation (including SKID) discards both slots. Reset dominates flush.
- Back-to-back throughput is 1 payload per cycle while i_ready = 1.
- Flush while in SKID empties both slots in one cycle. o_ready = 1 on the following cycle.

## Structure
- Shared package `mips_pkg`:
  - WORD_LEN and REG_32_ADDR_LEN constants.
  - `mem_wb_payload_t` packed struct.
  - State enum {EMPTY, FULL, SKID}.
- Sub-module `pipe_skid_buffer`: generic, parameter DATA_W. It holds the MAIN/SKID slots, the state machine and the flush logic.
- The top level handles:
  - Payload packing.
  - The x0 rule.
  - The writeback mux.
  - The forward tap.
  - The stall counter.

## Test plan
- Reset, then stream 4 payloads with i_ready = 1, dests 1–4 and ALU results 0x10–0x13. Required: outputs one cycle later in order, o_ready stays 1, o_stall_cnt = 0.
- Load with i_mem_rd_en = 1, memread 0xDEADBEEF, ALU result 0x40. Required: o_wb_data = 0xDEADBEEF. The same payload with i_mem_rd_en = 0 gives o_wb_data = 0x40.
- Hold i_ready = 0 with 2 payloads sent. Required: state SKID, o_ready = 0, o_stall_cnt increments by 1 per cycle. Then i_ready = 1 for 2 cycles: both payloads drain in order with none lost.
- i_dest = 0 with i_wb_en = 1. Required: o_wb_en = 0 and o_fwd_valid = 0.
- In SKID, assert i_flush together with a new i_valid. Required: the next cycle has o_valid = 0, o_ready = 1, and the new payload never appears.
- With CNT_W = 2, hold stall for 5 cycles. Required: o_stall_cnt stays at 3. Then assert i_sys_rst mid-stall: o_valid = 0 and o_stall_cnt = 0 on the next cycle.
